// File: rtl/sm_div32_seq_pkg.sv
// Shared definitions for the sign-magnitude sequential divider.
// Provides the FSM state encoding, the magnitude width, the quotient magnitude
// returned on divide-by-zero, and sign-magnitude helpers (zero test, -0 -> +0).
package sm_div32_seq_pkg;

   localparam int SM_WIDTH = 32;
   localparam int MAG_W    = SM_WIDTH - 1;

   localparam logic [MAG_W-1:0] DZ_QUOT_MAG = 31'h7FFFFFFF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // True when the magnitude field is zero (covers both +0 and -0).
   function automatic logic sm_is_zero(input logic [SM_WIDTH-1:0] x);
      return ((x & {1'b0, {MAG_W{1'b1}}}) == '0);
   endfunction

   // Canonicalise: any zero magnitude becomes +0.
   function automatic logic [SM_WIDTH-1:0] sm_norm(input logic [SM_WIDTH-1:0] x);
      return sm_is_zero(x) ? '0 : x;
   endfunction

endpackage

// File: rtl/sm_div32_seq_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   r      in   partial remainder (always < d)
//   dbit   in   next dividend magnitude bit, MSB first
//   d      in   divisor magnitude (non-zero)
//   r_next out  remainder after trial subtract / restore
//   q_bit  out  quotient bit produced by this iteration
module sm_div_step
   import sm_div32_seq_pkg::*;
#(
   parameter int MW = MAG_W
) (
   input  logic [MW-1:0] r,
   input  logic          dbit,
   input  logic [MW-1:0] d,
   output logic [MW-1:0] r_next,
   output logic          q_bit
);

   logic [MW:0]   trial;
   logic [MW+1:0] sum;
   logic          borrow;
   logic          sum_hi_unused;

   assign trial = {r, dbit};

   // trial + ~D + 1 with one extra bit: the top bit is the carry-out,
   // and a missing carry means trial < D (borrow -> restore).
   assign sum    = {1'b0, trial} + {1'b0, ~{1'b0, d}} + {{(MW+1){1'b0}}, 1'b1};
   assign borrow = ~sum[MW+1];

   // On a successful subtract the difference is < D, so it fits in MW bits;
   // bit MW of the sum is always zero there.
   assign sum_hi_unused = sum[MW];

   assign q_bit  = ~borrow;
   assign r_next = borrow ? trial[MW-1:0] : sum[MW-1:0];

endmodule

// File: rtl/sm_div32_seq.sv
// Multi-cycle sign-magnitude divider (restoring, one quotient bit per clock).
// Operands: bit WIDTH-1 = sign, lower bits = magnitude. One division in flight.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   dividend, divisor    sign-magnitude operands
//   out_valid/out_ready  result handshake, result held until accepted
//   quot, rem            sign-magnitude results (registered, canonical +0)
//   div_zero             divisor magnitude was zero
module sm_div32_seq
   import sm_div32_seq_pkg::*;
#(
   parameter int WIDTH = SM_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             div_zero
);

   localparam int         MW   = WIDTH - 1;
   localparam logic [4:0] LAST = 5'(MW - 1);

   state_t          state, state_nxt;
   logic [MW-1:0]   r_q, d_q, q_q;
   logic [MW-1:0]   r_nxt;
   logic            q_bit;
   logic            sd_q, sv_q, dz_q;
   logic [4:0]      count;
   logic            accept;
   logic            dvs_zero;

   assign in_ready = (state == S_IDLE);
   assign accept   = in_valid & in_ready;
   assign dvs_zero = sm_is_zero(divisor);

   // q_q starts as the dividend magnitude; each step shifts its MSB into the
   // remainder and a quotient bit in at the bottom, so after MW steps it holds
   // the quotient.
   sm_div_step #(.MW(MW)) u_step (
      .r      (r_q),
      .dbit   (q_q[MW-1]),
      .d      (d_q),
      .r_next (r_nxt),
      .q_bit  (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = dvs_zero ? S_DONE : S_RUN;
         S_RUN:  if (count == LAST) state_nxt = S_DONE;
         S_DONE: if (out_valid && out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q       <= '0;
         d_q       <= '0;
         q_q       <= '0;
         sd_q      <= 1'b0;
         sv_q      <= 1'b0;
         dz_q      <= 1'b0;
         count     <= '0;
         out_valid <= 1'b0;
         quot      <= '0;
         rem       <= '0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  // Signs latched already normalised so -0 behaves as +0.
                  sd_q     <= dividend[MW] & ~sm_is_zero(dividend);
                  sv_q     <= divisor[MW] & ~dvs_zero;
                  d_q      <= divisor[MW-1:0];
                  q_q      <= dividend[MW-1:0];
                  r_q      <= '0;
                  count    <= '0;
                  dz_q     <= dvs_zero;
                  div_zero <= 1'b0;
               end
            end
            S_RUN: begin
               r_q   <= r_nxt;
               q_q   <= {q_q[MW-2:0], q_bit};
               count <= count + 5'd1;
            end
            S_DONE: begin
               // First DONE cycle publishes the result; later cycles hold it.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  div_zero  <= dz_q;
                  if (dz_q) begin
                     quot <= {sd_q, DZ_QUOT_MAG};
                     rem  <= {sd_q, q_q};
                  end else begin
                     quot <= sm_norm({sd_q ^ sv_q, q_q});
                     rem  <= sm_norm({sd_q, r_q});
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sm_div32_seq.sv
module tb_sm_div32_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        in_ready, out_valid, div_zero;
   logic [31:0] quot, rem;

   int checks = 0;
   int failures = 0;

   sm_div32_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quot      (quot),
      .rem       (rem),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain integer divide on magnitudes, sign rules applied after.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r,
                                   output logic dz);
      int unsigned am, bm, qm, rm;
      logic sa, sb;
      am = {1'b0, a[30:0]};
      bm = {1'b0, b[30:0]};
      sa = a[31] && (am != 0);
      sb = b[31] && (bm != 0);
      if (bm == 0) begin
         dz = 1'b1;
         q  = {sa, 31'h7FFFFFFF};
         r  = {sa, am[30:0]};
      end else begin
         dz = 1'b0;
         qm = am / bm;
         rm = am % bm;
         q  = {(sa ^ sb) && (qm != 0), qm[30:0]};
         r  = {sa && (rm != 0), rm[30:0]};
      end
   endfunction

   // Accept one division, measure latency, check result, then consume it.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz);
      int lat;
      @(negedge clk);
      chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 100);
      chk({tag, " latency"}, lat, edz ? 32'd1 : 32'd32);
      chk({tag, " quot"}, quot, eq);
      chk({tag, " rem"}, rem, er);
      chk({tag, " div_zero"}, {31'b0, div_zero}, {31'b0, edz});
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, " out_valid_drop"}, {31'b0, out_valid}, 32'd0);
      chk({tag, " in_ready_back"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] eq, er, a, b;
      logic        edz;
      int          lat;

      vt.push_back('{32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0});
      vt.push_back('{32'h80000064, 32'h00000007, 32'h8000000E, 32'h80000002, 1'b0});
      vt.push_back('{32'h00000064, 32'h80000007, 32'h8000000E, 32'h00000002, 1'b0});
      vt.push_back('{32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 32'h00000000, 1'b0});
      vt.push_back('{32'h00000000, 32'h80000005, 32'h00000000, 32'h00000000, 1'b0});
      vt.push_back('{32'h80000000, 32'h00000003, 32'h00000000, 32'h00000000, 1'b0});
      vt.push_back('{32'h80000006, 32'h00000003, 32'h80000002, 32'h00000000, 1'b0});
      vt.push_back('{32'h00000002, 32'h80000007, 32'h00000000, 32'h00000002, 1'b0});
      vt.push_back('{32'h00000005, 32'h00000000, 32'h7FFFFFFF, 32'h00000005, 1'b1});
      vt.push_back('{32'h00000005, 32'h80000000, 32'h7FFFFFFF, 32'h00000005, 1'b1});
      vt.push_back('{32'h80000005, 32'h00000000, 32'hFFFFFFFF, 32'h80000005, 1'b1});
      vt.push_back('{32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'h00000000, 1'b1});

      // Reset state
      #2;
      chk("rst in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst quot", quot, 32'd0);
      chk("rst rem", rem, 32'd0);
      chk("rst div_zero", {31'b0, div_zero}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[i])
         run_div($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz);

      // Randomized against the reference model
      for (int i = 0; i < 30; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 9) == 0) b = b & 32'h80000000;
         ref_div(a, b, eq, er, edz);
         run_div($sformatf("rnd%0d", i), a, b, eq, er, edz);
      end

      // Back-pressure in DONE: result stable, new requests ignored
      ref_div(32'h000003E9, 32'h8000000A, eq, er, edz);
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 32'h000003E9;
      divisor  = 32'h8000000A;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 100);
      chk("hold latency", lat, 32'd32);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         dividend = $urandom;
         divisor  = 32'd1;
         @(posedge clk); #1;
         chk($sformatf("hold%0d out_valid", k), {31'b0, out_valid}, 32'd1);
         chk($sformatf("hold%0d in_ready", k), {31'b0, in_ready}, 32'd0);
         chk($sformatf("hold%0d quot", k), quot, eq);
         chk($sformatf("hold%0d rem", k), rem, er);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("hold release in_ready", {31'b0, in_ready}, 32'd1);
      chk("hold release out_valid", {31'b0, out_valid}, 32'd0);
      chk("hold keep quot", quot, eq);
      repeat (3) @(posedge clk);
      #1;
      chk("hold no phantom", {31'b0, out_valid}, 32'd0);

      // Reset in the middle of RUN abandons the operation
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 32'd1000000;
      divisor  = 32'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("midrst no result", {31'b0, out_valid}, 32'd0);
      run_div("post_rst", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
